// File: rtl/threshold_debounce_monitor_pkg.sv
// Shared constants for the threshold debounce monitor: FSM encoding,
// event direction codes and the one-hot comparison result codes.
package threshold_debounce_monitor_pkg;

   typedef enum logic [1:0] {
      S_BELOW   = 2'd0,
      S_RISING  = 2'd1,
      S_ABOVE   = 2'd2,
      S_FALLING = 2'd3
   } state_e;

   localparam logic EVT_RISE = 1'b1;
   localparam logic EVT_FALL = 1'b0;

   // One-hot packing of the comparator result as {greater, equal, less}
   localparam logic [2:0] CMP_LT = 3'b001;
   localparam logic [2:0] CMP_EQ = 3'b010;
   localparam logic [2:0] CMP_GT = 3'b100;

   // Advance the 4-bit streak counter
   function automatic logic [3:0] run_inc(input logic [3:0] run);
      return run + 4'd1;
   endfunction

endpackage

// File: rtl/threshold_debounce_monitor_cmp.sv
// 4-bit magnitude comparator: exactly one of lt/gt/eq is high for any a, b.
module threshold_debounce_monitor_cmp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   // Purely combinational magnitude compare of a against b
   always_comb begin
      lt = (a < b);
      gt = (a > b);
      eq = (a == b);
   end

endmodule

// File: rtl/threshold_debounce_monitor.sv
// Threshold crossing monitor: compares each accepted sample with its
// threshold, debounces the result with a 4-state FSM, and reports each
// debounced crossing as a handshaked event plus a saturating counter.
module threshold_debounce_monitor #(
   parameter int WIDTH    = 4,
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_valid,
   output logic             sample_ready,
   input  logic [WIDTH-1:0] sample,
   input  logic [WIDTH-1:0] threshold,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_dir,
   output logic             state_above,
   output logic [CNT_W-1:0] cross_count
);

   import threshold_debounce_monitor_pkg::*;

   localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q,       state_d;
   logic [3:0]       run_q,         run_d;
   logic             evt_valid_q,   evt_valid_d;
   logic             evt_dir_q,     evt_dir_d;
   logic             state_above_q, state_above_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;

   logic             cmp_lt_s, cmp_gt_s, cmp_eq_s;
   logic [2:0]       cmp_s;
   logic             accept_s;
   logic             fire_s;
   logic             fire_dir_s;
   logic [3:0]       run_next_s;

   threshold_debounce_monitor_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a  (sample),
      .b  (threshold),
      .lt (cmp_lt_s),
      .gt (cmp_gt_s),
      .eq (cmp_eq_s)
   );

   // Handshake: a new sample may enter unless an unconsumed event blocks it
   always_comb begin
      sample_ready = !evt_valid_q || evt_ready;
      accept_s     = sample_valid && sample_ready;
      cmp_s        = {cmp_gt_s, cmp_eq_s, cmp_lt_s};
      run_next_s   = run_inc(run_q);
   end

   // Debounce FSM next state, event register update and crossing counter
   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      fire_s     = 1'b0;
      fire_dir_s = EVT_RISE;

      if (accept_s) begin
         case (state_q)
            S_BELOW: begin
               if (cmp_s == CMP_GT) begin
                  fire_dir_s = EVT_RISE;
                  if (DEB == 4'd1) begin
                     state_d = S_ABOVE;
                     run_d   = 4'd0;
                     fire_s  = 1'b1;
                  end else begin
                     state_d = S_RISING;
                     run_d   = 4'd1;
                  end
               end else begin
                  run_d = 4'd0;
               end
            end
            S_RISING: begin
               fire_dir_s = EVT_RISE;
               if (cmp_s == CMP_GT) begin
                  if (run_next_s == DEB) begin
                     state_d = S_ABOVE;
                     run_d   = 4'd0;
                     fire_s  = 1'b1;
                  end else begin
                     run_d = run_next_s;
                  end
               end else begin
                  state_d = S_BELOW;
                  run_d   = 4'd0;
               end
            end
            S_ABOVE: begin
               fire_dir_s = EVT_FALL;
               if (cmp_s == CMP_LT) begin
                  if (DEB == 4'd1) begin
                     state_d = S_BELOW;
                     run_d   = 4'd0;
                     fire_s  = 1'b1;
                  end else begin
                     state_d = S_FALLING;
                     run_d   = 4'd1;
                  end
               end else begin
                  run_d = 4'd0;
               end
            end
            S_FALLING: begin
               fire_dir_s = EVT_FALL;
               if (cmp_s == CMP_LT) begin
                  if (run_next_s == DEB) begin
                     state_d = S_BELOW;
                     run_d   = 4'd0;
                     fire_s  = 1'b1;
                  end else begin
                     run_d = run_next_s;
                  end
               end else begin
                  state_d = S_ABOVE;
                  run_d   = 4'd0;
               end
            end
            default: begin
               state_d = S_BELOW;
               run_d   = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
         run_d   = run_q;
      end

      // A consumed event clears; a fire on the same edge takes precedence
      if (fire_s) begin
         evt_valid_d = 1'b1;
         evt_dir_d   = fire_dir_s;
         cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_d = 1'b0;
         evt_dir_d   = 1'b0;
         cnt_d       = cnt_q;
      end else begin
         evt_valid_d = evt_valid_q;
         evt_dir_d   = evt_dir_q;
         cnt_d       = cnt_q;
      end

      state_above_d = (state_d == S_ABOVE) || (state_d == S_FALLING);
   end

   // State, event and counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_BELOW;
         run_q         <= 4'd0;
         evt_valid_q   <= 1'b0;
         evt_dir_q     <= 1'b0;
         state_above_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         run_q         <= run_d;
         evt_valid_q   <= evt_valid_d;
         evt_dir_q     <= evt_dir_d;
         state_above_q <= state_above_d;
         cnt_q         <= cnt_d;
      end
   end

   assign evt_valid   = evt_valid_q;
   assign evt_dir     = evt_dir_q;
   assign state_above = state_above_q;
   assign cross_count = cnt_q;

endmodule
